// File: rtl/add_acc_pkg.sv
// Shared definitions for the add_accumulator block: FSM state encoding and
// default operand/accumulator width and beat-count field width.
package add_acc_pkg;

  localparam int N_DEF  = 8;
  localparam int LW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_accumulator_if.sv
// Job/operand/result handshake bundle between a job source and add_accumulator.
// The master side issues jobs and beats and consumes results; the slave side is the accumulator.
interface add_accumulator_if #(
  parameter int N  = add_acc_pkg::N_DEF,
  parameter int LW = add_acc_pkg::LW_DEF
);

  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_ovf;
  logic          busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface

// File: rtl/ripplecarryadderN_generate.sv
// N-bit ripple-carry adder built from a generated chain of full adders.
module ripplecarryadderN_generate #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/add_accumulator.sv
// Accumulates len unsigned operand beats into an N-bit sum with a sticky carry-out flag.
// Define ADD_ACC_SATURATE_EN to clamp the sum at all-ones on carry-out instead of wrapping.
module add_accumulator
  import add_acc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = LW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  add_accumulator_if.slave   bus
);

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q,   acc_d;
  logic          ovf_q,   ovf_d;
  logic [LW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  res_q,   res_d;
  logic          reso_q,  reso_d;

  logic [N-1:0]  add_sum;
  logic          add_cout;
  logic [N-1:0]  beat_acc;
  logic          beat_ovf;

  function automatic logic [N-1:0] sat_or_wrap(input logic [N-1:0] s, input logic c);
`ifdef ADD_ACC_SATURATE_EN
    return c ? {N{1'b1}} : s;
`else
    return s | {N{1'b0 & c}};
`endif
  endfunction

  ripplecarryadderN_generate #(
    .N (N)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (bus.in_data),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign beat_acc = sat_or_wrap(add_sum, add_cout);
  assign beat_ovf = ovf_q | add_cout;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    reso_d  = reso_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.len != '0) begin
            cnt_d   = bus.len;
            state_d = ACC;
          end else begin
            // Empty job: publish a zero result straight away.
            cnt_d   = '0;
            res_d   = '0;
            reso_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = beat_acc;
          ovf_d = beat_ovf;
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            res_d   = beat_acc;
            reso_d  = beat_ovf;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      reso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      reso_q  <= reso_d;
    end
  end

  // Result registers only load on entry to DONE, so out_sum/out_ovf hold between jobs.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sum   = res_q;
  assign bus.out_ovf   = reso_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed self-checking bench for add_accumulator (N=8, LW=4) with a job-level result model.
module tb_add_accumulator;

  localparam int N  = 8;
  localparam int LW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  add_accumulator_if #(.N(N), .LW(LW)) bus ();

  add_accumulator #(.N(N), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int exp_sum = 0;
  bit exp_ovf = 1'b0;
  bit exp_live = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job-level model: sum the beats as plain integers, flag any overflow past 2^N.
  function automatic void model(input int beats[$], output int s, output bit o);
    int acc;
    acc = 0;
    o   = 1'b0;
    foreach (beats[i]) begin
      acc = acc + beats[i];
      if (acc >= (1 << N)) begin
        o = 1'b1;
`ifdef ADD_ACC_SATURATE_EN
        acc = (1 << N) - 1;
`else
        acc = acc - (1 << N);
`endif
      end
    end
    s = acc;
  endfunction

  always @(negedge clk) begin
    chk("busy_decode", int'(bus.busy), int'(bus.in_ready | bus.out_valid));
    chk("ready_valid_excl", int'(bus.in_ready & bus.out_valid), 0);
    if (bus.out_valid) begin
      chk("cmp_live_job", int'(exp_live), 1);
      chk("cmp_sum", int'(bus.out_sum), exp_sum);
      chk("cmp_ovf", int'(bus.out_ovf), int'(exp_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int beats[$]);
    model(beats, exp_sum, exp_ovf);
    exp_live  = 1'b1;
    bus.start = 1'b1;
    bus.len   = LW'(len);
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = N'(d);
    chk("beat_accept", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  int'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    chk({tag, "_out_sum"},   int'(bus.out_sum), 0);
    chk({tag, "_out_ovf"},   int'(bus.out_ovf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q[$];
    int ms;
    bit mo;

    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    q = {10, 20, 30};
    model(q, ms, mo);
    chk("model_60_sum", ms, 60);
    chk("model_60_ovf", int'(mo), 0);
    q = {200, 100};
    model(q, ms, mo);
`ifdef ADD_ACC_SATURATE_EN
    chk("model_sat_sum", ms, 255);
`else
    chk("model_wrap_sum", ms, 44);
`endif
    chk("model_ovf", int'(mo), 1);

    #1;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("idle");

    // Three back-to-back beats.
    q = {10, 20, 30};
    start_job(3, q);
    chk("t1_in_ready", int'(bus.in_ready), 1);
    chk("t1_busy", int'(bus.busy), 1);
    chk("t1_valid_early", int'(bus.out_valid), 0);
    send(10);
    send(20);
    chk("t1_not_done", int'(bus.out_valid), 0);
    send(30);
    chk("t1_valid", int'(bus.out_valid), 1);
    chk("t1_sum", int'(bus.out_sum), 60);
    chk("t1_ovf", int'(bus.out_ovf), 0);
    release_result();
    chk("t1_idle_valid", int'(bus.out_valid), 0);
    chk("t1_idle_busy", int'(bus.busy), 0);
    chk("t1_hold_sum", int'(bus.out_sum), 60);

    // Carry-out on the second beat.
    q = {200, 100};
    start_job(2, q);
    send(200);
    send(100);
    chk("t2_valid", int'(bus.out_valid), 1);
`ifdef ADD_ACC_SATURATE_EN
    chk("t2_sum", int'(bus.out_sum), 255);
`else
    chk("t2_sum", int'(bus.out_sum), 44);
`endif
    chk("t2_ovf", int'(bus.out_ovf), 1);
    release_result();

    // Empty job goes straight to DONE.
    q.delete();
    chk("t3_pre_ready", int'(bus.in_ready), 0);
    start_job(0, q);
    chk("t3_valid", int'(bus.out_valid), 1);
    chk("t3_sum", int'(bus.out_sum), 0);
    chk("t3_ovf", int'(bus.out_ovf), 0);
    chk("t3_in_ready", int'(bus.in_ready), 0);
    release_result();
    chk("t3_after_ready", int'(bus.in_ready), 0);

    // Beats with bubbles, then back-pressure with ignored start pulses.
    q = {1, 1, 1, 1};
    start_job(4, q);
    for (int i = 0; i < 4; i++) begin
      send(1);
      if (i < 3) begin
        step();
        step();
        chk("t4_bubble_valid", int'(bus.out_valid), 0);
        chk("t4_bubble_ready", int'(bus.in_ready), 1);
      end
    end
    chk("t4_valid", int'(bus.out_valid), 1);
    chk("t4_sum", int'(bus.out_sum), 4);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.len   = LW'(5);
      step();
      chk("t4_hold_valid", int'(bus.out_valid), 1);
      chk("t4_hold_sum", int'(bus.out_sum), 4);
      chk("t4_hold_ovf", int'(bus.out_ovf), 0);
      chk("t4_hold_ready", int'(bus.in_ready), 0);
    end
    bus.start = 1'b0;
    release_result();
    chk("t4_start_ignored", int'(bus.busy), 0);
    step();
    chk("t4_still_idle", int'(bus.busy), 0);

    // Asynchronous reset mid-job discards it.
    q = {5, 6, 7};
    start_job(3, q);
    send(5);
    send(6);
    #2;
    rst_n    = 1'b0;
    exp_live = 1'b0;
    #1;
    chk_all_zero("t5_async");
    step();
    chk_all_zero("t5_held");
    rst_n = 1'b1;
    step();
    step();
    chk("t5_no_partial", int'(bus.out_valid), 0);
    chk("t5_idle", int'(bus.busy), 0);
    q = {7};
    start_job(1, q);
    send(7);
    chk("t5_valid", int'(bus.out_valid), 1);
    chk("t5_sum", int'(bus.out_sum), 7);
    chk("t5_ovf", int'(bus.out_ovf), 0);
    release_result();

    // Maximum len runs all fifteen beats without counter wrap.
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(i + 1);
    start_job(15, q);
    for (int i = 0; i < 15; i++) begin
      chk("t6_not_done", int'(bus.out_valid), 0);
      send(i + 1);
    end
    chk("t6_valid", int'(bus.out_valid), 1);
    chk("t6_sum", int'(bus.out_sum), 120);
    chk("t6_ovf", int'(bus.out_ovf), 0);
    release_result();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
